// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS CPU: word-addressed RAM served one access at a time
// after WAIT_CYCLES wait states, with a one-cycle ready pulse. Define DMEM_STATS_EN for access counters.
module mips_dmem_responder #(
    parameter int NMEM        = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memread,
    input  logic        memwrite,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef DMEM_STATS_EN
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`else
    output logic        err
`endif
);

    localparam int AW = (NMEM > 1) ? $clog2(NMEM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] addr_reg, wdata_reg;
    logic        rd_reg, wr_reg;
    logic        latch;
    logic        ready_reg, ready_next;
    logic        err_reg, err_next;
    logic        rvalid_reg, rvalid_next;
    logic [31:0] mem_q;
    logic [31:0] mem [NMEM];

    logic          req, bad, access, mem_we;
    logic [AW-1:0] widx;

    assign req    = memread | memwrite;
    assign widx   = addr_reg[AW+1:2];
    assign bad    = (addr_reg[1:0] != 2'b00) ||
                    (addr_reg[31:2] >= 30'(NMEM)) ||
                    (rd_reg && wr_reg);
    assign access = (state_reg == S_WAIT) && req && (count_reg == 4'd0);
    assign mem_we = access && wr_reg && !bad;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        latch       = 1'b0;
        ready_next  = 1'b0;
        err_next    = 1'b0;
        rvalid_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    state_next = S_WAIT;
                    count_next = 4'(WAIT_CYCLES);
                    latch      = 1'b1;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_next = S_IDLE;
                    count_next = 4'd0;
                end else if (count_reg != 4'd0) begin
                    count_next = count_reg - 4'd1;
                end else begin
                    state_next  = S_DONE;
                    ready_next  = 1'b1;
                    err_next    = bad;
                    rvalid_next = rd_reg && !bad;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            count_reg  <= 4'd0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            ready_reg  <= 1'b0;
            err_reg    <= 1'b0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            ready_reg  <= ready_next;
            err_reg    <= err_next;
            rvalid_reg <= rvalid_next;
            if (latch) begin
                addr_reg  <= addr;
                wdata_reg <= wdata;
                rd_reg    <= memread;
                wr_reg    <= memwrite;
            end
        end
    end

    // RAM has no reset; its read port is registered and only exposed while a good load is in DONE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= wdata_reg;
        end
        mem_q <= mem[widx];
    end

    assign rdata = rvalid_reg ? mem_q : 32'd0;
    assign ready = ready_reg;
    assign err   = err_reg;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count_reg, wr_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_reg <= 16'd0;
            wr_count_reg <= 16'd0;
        end else begin
            if (access && rd_reg && !bad && rd_count_reg != 16'hFFFF) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
            if (mem_we && wr_count_reg != 16'hFFFF) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: one instance with two wait states, one with none.
module tb_mips_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          issue;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [31:0] addr0, wdata0, rdata0;
    logic        rd0, wr0, ready0, err0;
    logic [31:0] addr1, wdata1, rdata1;
    logic        rd1, wr1, ready1, err1;
`ifdef DMEM_STATS_EN
    logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_rdc = 0;
    int   exp_wrc = 0;

    mips_dmem_responder #(.NMEM(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr0), .wdata(wdata0),
        .memread(rd0), .memwrite(wr0), .rdata(rdata0), .ready(ready0),
`ifdef DMEM_STATS_EN
        .err(err0), .rd_count(rdc0), .wr_count(wrc0)
`else
        .err(err0)
`endif
    );

    mips_dmem_responder #(.NMEM(64), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr1), .wdata(wdata1),
        .memread(rd1), .memwrite(wr1), .rdata(rdata1), .ready(ready1),
`ifdef DMEM_STATS_EN
        .err(err1), .rd_count(rdc1), .wr_count(wrc1)
`else
        .err(err1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever a DUT raises ready.
    always @(negedge clk) begin
        exp_t e;
        if (ready0) begin
            if (q0.size() == 0) begin
                cmp("dut0 unexpected ready", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                $display("resp dut0: rdata=%h err=%0d latency=%0d", rdata0, err0, cyc - e.issue);
                cmp("dut0 rdata", rdata0, e.rdata);
                cmp("dut0 err", 32'(err0), 32'(e.err));
                cmp("dut0 latency", 32'(cyc - e.issue), 32'd1);
            end
        end
        if (ready1) begin
            if (q1.size() == 0) begin
                cmp("dut1 unexpected ready", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                $display("resp dut1: rdata=%h err=%0d latency=%0d", rdata1, err1, cyc - e.issue);
                cmp("dut1 rdata", rdata1, e.rdata);
                cmp("dut1 err", 32'(err1), 32'(e.err));
                cmp("dut1 latency", 32'(cyc - e.issue), 32'd3);
            end
        end
    end

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic perturb);
        exp_t e;
        bit   got;
        @(negedge clk);
        $display("txn dut%0d: rd=%0d wr=%0d addr=%h wdata=%h expect rdata=%h err=%0d",
                 sel, rd, wr, a, d, exp_rdata, exp_err);
        drive(sel, rd, wr, a, d);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.issue = cyc + 1;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        if (sel == 1 && !exp_err) begin
            if (rd) exp_rdc++; else exp_wrc++;
        end
        if (perturb) begin
            @(posedge clk);
            #1 drive(sel, rd, wr, a ^ 32'h4, ~d);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 0 && ready0) || (sel == 1 && ready1)) begin
                got = 1'b1;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        if (!got) begin
            cmp("ready timeout", 32'd0, 32'd1);
            if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        cmp("reset ready", 32'(ready1), 32'd0);
        cmp("reset err", 32'(err1), 32'd0);
        cmp("reset rdata", rdata1, 32'd0);
        rst_n = 1'b1;

        access(1, 0, 1, 32'h4,        32'hDEADBEEF, 32'h0,        0, 0);
        access(1, 1, 0, 32'h4,        32'h0,        32'hDEADBEEF, 0, 0);
        access(1, 0, 1, 32'hFC,       32'hCAFEF00D, 32'h0,        0, 0);
        access(1, 1, 0, 32'h6,        32'h0,        32'h0,        1, 0);
        access(1, 0, 1, 32'h100,      32'h12345678, 32'h0,        1, 0);
        access(1, 0, 1, 32'h40000004, 32'h12345678, 32'h0,        1, 0);
        access(1, 1, 0, 32'hFC,       32'h0,        32'hCAFEF00D, 0, 0);
        access(1, 1, 0, 32'h4,        32'h0,        32'hDEADBEEF, 0, 0);
        access(1, 0, 1, 32'h8,        32'h11112222, 32'h0,        0, 0);
        access(1, 1, 1, 32'h8,        32'h99999999, 32'h0,        1, 0);
        access(1, 1, 0, 32'h8,        32'h0,        32'h11112222, 0, 0);
        access(1, 0, 1, 32'hC,        32'h0BADC0DE, 32'h0,        0, 0);

        // Store dropped after one wait cycle: no ready, RAM untouched.
        @(negedge clk);
        $display("txn dut1: store addr=0000000c wdata=aaaa5555 dropped mid-wait");
        drive(1, 1'b0, 1'b1, 32'hC, 32'hAAAA5555);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp("abort no ready", 32'(ready1), 32'd0);
        end
        access(1, 1, 0, 32'hC, 32'h0, 32'h0BADC0DE, 0, 0);

        // Address/data changed while waiting must be ignored.
        access(1, 0, 1, 32'h10, 32'h00000055, 32'h0, 0, 1);
        access(1, 1, 0, 32'h10, 32'h0, 32'h00000055, 0, 0);

`ifdef DMEM_STATS_EN
        @(negedge clk);
        cmp("rd_count", 32'(rdc1), 32'(exp_rdc));
        cmp("wr_count", 32'(wrc1), 32'(exp_wrc));
`endif

        // Reset pulsed mid-wait on a store.
        @(negedge clk);
        $display("txn dut1: store addr=0000000c wdata=aaaa5555 reset mid-wait");
        drive(1, 1'b0, 1'b1, 32'hC, 32'hAAAA5555);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst wait ready", 32'(ready1), 32'd0);
        cmp("rst wait rdata", rdata1, 32'd0);
        cmp("rst wait err", 32'(err1), 32'd0);
        exp_rdc = 0;
        exp_wrc = 0;
`ifdef DMEM_STATS_EN
        cmp("rst rd_count", 32'(rdc1), 32'd0);
        cmp("rst wr_count", 32'(wrc1), 32'd0);
`endif
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 1, 0, 32'hC, 32'h0, 32'h0BADC0DE, 0, 0);

        // Reset asserted while ready is high clears outputs without waiting for a clock.
        access(1, 1, 0, 32'h4, 32'h0, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
        q1.push_back('{rdata: 32'h11112222, err: 1'b0, issue: cyc + 1});
        $display("txn dut1: load addr=00000008 then reset during ready");
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ready1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                cmp("ready timeout", 32'd0, 32'd1);
                void'(q1.pop_front());
            end
        end
        #1 rst_n = 1'b0;
        #1;
        cmp("rst done ready", 32'(ready1), 32'd0);
        cmp("rst done rdata", rdata1, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero wait states.
        access(0, 0, 1, 32'h0, 32'h00000001, 32'h0,        0, 0);
        access(0, 1, 0, 32'h0, 32'h0,        32'h00000001, 0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
